pulse_burst_gen: RTL and testbench

//  Parametrised successor to the fixed divide-by-20 pulse maker.

---
 rtl/pulse_burst_gen_pkg.sv | 17 +
 rtl/pulse_burst_gen_div_tick.sv | 55 +++++
 rtl/pulse_burst_gen.sv | 174 +++++++++++++++++
 tb/tb_pulse_burst_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_gen_pkg.sv
// Shared definitions for the pulse burst generator: FSM state encoding and
// the half-period the divider holds out of reset.
package pulse_burst_gen_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_HALF_PERIOD = 32'd10;

    // A programmed half-period of 0 behaves as 1, so the terminal count is H-1 floored at 0.
    function automatic logic [31:0] half_to_term(input logic [31:0] half_period);
        half_to_term = (half_period == 32'd0) ? 32'd0 : (half_period - 32'd1);
    endfunction

endpackage

// File: rtl/pulse_burst_gen_div_tick.sv
// Half-period divider: latches the terminal count on load and emits a
// one-cycle tick on the enabled cycle where the count reaches it.
module div_tick
    import pulse_burst_gen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] half_period,
    input  logic             clr,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] term_q;
    logic [DIV_W-1:0] term_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == term_q);

    // Next-state for the terminal count and the running count; load beats clear beats enable.
    always_comb begin
        term_d = term_q;
        cnt_d  = cnt_q;
        if (load) begin
            term_d = DIV_W'(half_to_term(32'(half_period)));
            cnt_d  = {DIV_W{1'b0}};
        end else if (clr) begin
            cnt_d  = {DIV_W{1'b0}};
        end else if (en) begin
            if (tick) begin
                cnt_d = {DIV_W{1'b0}};
            end else begin
                cnt_d = cnt_q + DIV_W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_q <= DIV_W'(half_to_term(32'(DEFAULT_HALF_PERIOD)));
            cnt_q  <= {DIV_W{1'b0}};
        end else begin
            term_q <= term_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_burst_gen.sv
// Programmable square-wave pulse train generator with burst/continuous modes,
// start/stop/busy/done handshake and a freeze while the PLL is unlocked.
module pulse_burst_gen
    import pulse_burst_gen_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             locked,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] cfg_half_period,
    input  logic [CNT_W-1:0] cfg_num_pulses,
    input  logic             cfg_continuous,
    output logic             clk_out,
    output logic             pulse_stb,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic             clk_out_q, clk_out_d;
    logic             pulse_stb_q, pulse_stb_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             cont_q, cont_d;

    logic             div_load;
    logic             div_clr;
    logic             div_en;
    logic             div_tick_s;
    logic             stop_now;
    logic [CNT_W-1:0] cnt_inc;

    div_tick #(
        .DIV_W (DIV_W)
    ) u_div_tick (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .load        (div_load),
        .half_period (cfg_half_period),
        .clr         (div_clr),
        .en          (div_en),
        .tick        (div_tick_s)
    );

    assign cnt_inc  = pulse_cnt_q + CNT_W'(1'b1);
    assign stop_now = stop || stop_pend_q;

    // FSM, output toggle, pulse counter and handshake next-state.
    always_comb begin
        state_d     = state_q;
        clk_out_d   = clk_out_q;
        pulse_stb_d = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        num_d       = num_q;
        cont_d      = cont_q;
        div_load    = 1'b0;
        div_clr     = 1'b0;
        div_en      = 1'b0;
        if (!locked) begin
            pulse_stb_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_d       = cfg_num_pulses;
                        cont_d      = cfg_continuous;
                        pulse_cnt_d = {CNT_W{1'b0}};
                        stop_pend_d = 1'b0;
                        clk_out_d   = 1'b0;
                        div_load    = 1'b1;
                        if (!cfg_continuous && (cfg_num_pulses == {CNT_W{1'b0}})) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    div_en = 1'b1;
                    if (!clk_out_q) begin
                        // A stop seen while low ends the run before any rise, so no runt pulse.
                        if (stop_now) begin
                            state_d     = ST_IDLE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                            div_clr     = 1'b1;
                        end else if (div_tick_s) begin
                            clk_out_d   = 1'b1;
                            pulse_stb_d = 1'b1;
                        end else begin
                            clk_out_d   = 1'b0;
                        end
                    end else begin
                        if (stop) begin
                            stop_pend_d = 1'b1;
                        end else begin
                            stop_pend_d = stop_pend_q;
                        end
                        if (div_tick_s) begin
                            clk_out_d   = 1'b0;
                            pulse_cnt_d = cnt_inc;
                            if (stop_now || (!cont_q && (cnt_inc == num_q))) begin
                                state_d     = ST_IDLE;
                                busy_d      = 1'b0;
                                done_d      = 1'b1;
                                stop_pend_d = 1'b0;
                                div_clr     = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            clk_out_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    clk_out_d   = 1'b0;
                    busy_d      = 1'b0;
                    stop_pend_d = 1'b0;
                    div_clr     = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset has priority over everything else.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            clk_out_q   <= 1'b0;
            pulse_stb_q <= 1'b0;
            pulse_cnt_q <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            num_q       <= {CNT_W{1'b0}};
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_out_q   <= clk_out_d;
            pulse_stb_q <= pulse_stb_d;
            pulse_cnt_q <= pulse_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            num_q       <= num_d;
            cont_q      <= cont_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign pulse_stb = pulse_stb_q;
    assign pulse_cnt = pulse_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen with hand-computed expectations and a
// negedge monitor that counts busy cycles, strobes, dones and phase lengths.
module tb_pulse_burst_gen;

    localparam int DIV_W = 16;
    localparam int CNT_W = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             locked;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] cfg_half_period;
    logic [CNT_W-1:0] cfg_num_pulses;
    logic             cfg_continuous;
    logic             clk_out;
    logic             pulse_stb;
    logic [CNT_W-1:0] pulse_cnt;
    logic             busy;
    logic             done;

    pulse_burst_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .locked          (locked),
        .start           (start),
        .stop            (stop),
        .cfg_half_period (cfg_half_period),
        .cfg_num_pulses  (cfg_num_pulses),
        .cfg_continuous  (cfg_continuous),
        .clk_out         (clk_out),
        .pulse_stb       (pulse_stb),
        .pulse_cnt       (pulse_cnt),
        .busy            (busy),
        .done            (done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    int n_busy = 0, n_stb = 0, n_done = 0, n_stb_bad = 0;
    int run_len = 0, last_hi_len = 0, last_lo_len = 0;
    logic prev_clk = 1'b0;

    // Running totals sampled mid-cycle; the bench reads deltas around each run.
    always @(negedge sys_clk) begin
        if (busy === 1'b1)      n_busy <= n_busy + 1;
        if (pulse_stb === 1'b1) n_stb  <= n_stb + 1;
        if (done === 1'b1)      n_done <= n_done + 1;
        if ((pulse_stb === 1'b1) && !((clk_out === 1'b1) && (prev_clk === 1'b0)))
            n_stb_bad <= n_stb_bad + 1;
        if (clk_out !== prev_clk) begin
            if (prev_clk === 1'b1) last_hi_len <= run_len;
            else                   last_lo_len <= run_len;
            run_len <= 1;
        end else begin
            run_len <= run_len + 1;
        end
        prev_clk <= clk_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy === 1'b1) && (k < budget)) begin
            step(1);
            k++;
        end
        if (busy !== 1'b0) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_clk_high(input string tag, input int budget);
        int k = 0;
        while ((clk_out !== 1'b1) && (k < budget)) begin
            step(1);
            k++;
        end
        if (clk_out !== 1'b1) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic go(input logic [DIV_W-1:0] h, input logic [CNT_W-1:0] n, input logic cont);
        cfg_half_period = h;
        cfg_num_pulses  = n;
        cfg_continuous  = cont;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int s_busy, s_stb, s_done;
    logic [31:0] hv;

    task automatic snap();
        s_busy = n_busy;
        s_stb  = n_stb;
        s_done = n_done;
    endtask

    initial begin
        sys_rst = 1'b1; locked = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_half_period = 16'd0; cfg_num_pulses = 4'd0; cfg_continuous = 1'b0;
        step(3);
        check_eq("reset_outs", {27'd0, clk_out, pulse_stb, busy, done, 1'b0}, 32'd0);
        check_eq("reset_cnt", 32'(pulse_cnt), 32'd0);
        sys_rst = 1'b0;
        step(2);

        // 1: H=10, N=3 burst
        snap();
        go(16'd10, 4'd3, 1'b0);
        check_eq("t1_busy_rise", {30'd0, busy, clk_out}, 32'h2);
        wait_idle("t1", 200);
        check_eq("t1_done_at_end", {30'd0, done, clk_out}, 32'h2);
        step(2);
        check_eq("t1_busy_cycles", 32'(n_busy - s_busy), 32'd60);
        check_eq("t1_strobes", 32'(n_stb - s_stb), 32'd3);
        check_eq("t1_done_count", 32'(n_done - s_done), 32'd1);
        check_eq("t1_pulse_cnt", 32'(pulse_cnt), 32'd3);
        check_eq("t1_high_len", 32'(last_hi_len), 32'd10);
        check_eq("t1_low_len", 32'(last_lo_len), 32'd10);

        // 2: H=1 and H=0 with N=1 give the same two-cycle run
        for (int h = 1; h >= 0; h--) begin
            go(DIV_W'(h), 4'd1, 1'b0);
            check_eq($sformatf("t2_h%0d_c1", h), {28'd0, busy, clk_out, pulse_stb, done}, 32'h8);
            step(1);
            check_eq($sformatf("t2_h%0d_c2", h), {28'd0, busy, clk_out, pulse_stb, done}, 32'he);
            step(1);
            check_eq($sformatf("t2_h%0d_end", h), {28'd0, busy, clk_out, pulse_stb, done}, 32'h1);
            check_eq($sformatf("t2_h%0d_cnt", h), 32'(pulse_cnt), 32'd1);
            step(1);
            check_eq($sformatf("t2_h%0d_after", h), {28'd0, busy, clk_out, pulse_stb, done}, 32'h0);
        end

        // 3: N=0 burst finishes immediately with no activity
        snap();
        go(16'd5, 4'd0, 1'b0);
        check_eq("t3_done", {28'd0, busy, clk_out, pulse_stb, done}, 32'h1);
        step(1);
        check_eq("t3_after", {28'd0, busy, clk_out, pulse_stb, done}, 32'h0);
        step(3);
        check_eq("t3_no_busy", 32'(n_busy - s_busy), 32'd0);
        check_eq("t3_no_stb", 32'(n_stb - s_stb), 32'd0);

        // 4: continuous, H=2, counter wrap and both stop cases
        go(16'd2, 4'd0, 1'b1);
        for (int k = 0; (k < 200) && (pulse_cnt !== 4'd15); k++) step(1);
        check_eq("t4_cnt15", 32'(pulse_cnt), 32'd15);
        for (int k = 0; (k < 20) && (pulse_cnt === 4'd15); k++) step(1);
        check_eq("t4_wrap", {27'd0, busy, pulse_cnt}, 32'h10);
        wait_clk_high("t4_rise", 20);
        check_eq("t4_stb_on_rise", 32'(pulse_stb), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("t4_high_finishes", {29'd0, busy, clk_out, done}, 32'h6);
        step(1);
        check_eq("t4_stop_fall", {29'd0, busy, clk_out, done}, 32'h1);
        check_eq("t4_stop_cnt", 32'(pulse_cnt), 32'd1);
        step(1);
        check_eq("t4_done_once", 32'(done), 32'd0);
        snap();
        go(16'd2, 4'd0, 1'b1);
        check_eq("t4_restart", {27'd0, busy, pulse_cnt}, 32'h10);
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("t4_stop_low", {28'd0, busy, clk_out, pulse_stb, done}, 32'h1);
        check_eq("t4_stop_low_cnt", 32'(pulse_cnt), 32'd0);
        step(2);
        check_eq("t4_no_runt", 32'(n_stb - s_stb), 32'd0);

        // 5: H=10, N=5 with locked dropped for 7 cycles in a high phase
        snap();
        go(16'd10, 4'd5, 1'b0);
        wait_clk_high("t5_rise", 30);
        step(3);
        locked = 1'b0;
        step(7);
        hv = {27'd0, clk_out, busy, pulse_cnt};
        check_eq("t5_hold", hv, 32'h30);
        check_eq("t5_no_strobes", {30'd0, pulse_stb, done}, 32'd0);
        locked = 1'b1;
        wait_idle("t5", 300);
        step(2);
        check_eq("t5_busy_cycles", 32'(n_busy - s_busy), 32'd107);
        check_eq("t5_pulse_cnt", 32'(pulse_cnt), 32'd5);
        check_eq("t5_strobes", 32'(n_stb - s_stb), 32'd5);
        check_eq("t5_done_count", 32'(n_done - s_done), 32'd1);

        // 6a: start while busy is ignored
        snap();
        go(16'd3, 4'd2, 1'b0);
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_idle("t6a", 100);
        step(1);
        check_eq("t6a_busy_cycles", 32'(n_busy - s_busy), 32'd12);
        check_eq("t6a_pulse_cnt", 32'(pulse_cnt), 32'd2);

        // 6b: reset mid-run
        go(16'd10, 4'd5, 1'b0);
        step(24);
        check_eq("t6b_pre_cnt", 32'(pulse_cnt), 32'd1);
        snap();
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        check_eq("t6b_reset_outs", {27'd0, clk_out, pulse_stb, busy, done, pulse_cnt}, 32'd0);
        step(5);
        check_eq("t6b_no_done", 32'(n_done - s_done), 32'd0);

        // 6c: start and stop together in IDLE starts the run
        cfg_half_period = 16'd2; cfg_num_pulses = 4'd3; cfg_continuous = 1'b0;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check_eq("t6c_started", 32'(busy), 32'd1);
        step(3);
        check_eq("t6c_still_busy", 32'(busy), 32'd1);
        wait_idle("t6c", 50);
        check_eq("t6c_pulse_cnt", 32'(pulse_cnt), 32'd3);
        check_stb_alignment();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic check_stb_alignment();
        check_eq("stb_aligned_rise", 32'(n_stb_bad), 32'd0);
    endtask

endmodule
